// File: rtl/cfi_alarm_ctrl.sv
// CFI violation alarm controller: captures fault PC, stalls commit, raises irq, re-arms checker, escalates to lockdown.
// Latency: 1 cycle from violation_i sampled at an edge to halt/irq/fault_pc/count visible; all outputs registered.
// Backpressure: no input handshake; halt_commit_o throttles the commit stage for as long as any alarm is outstanding.
module cfi_alarm_ctrl #(
   parameter int PC_W        = 64,
   parameter int CNT_W       = 8,
   parameter int MAX_VIOL    = 4,
   parameter int ACK_TIMEOUT = 256
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             violation_i,
   input  logic             commit_valid_i,
   input  logic [PC_W-1:0]  commit_pc_i,
   input  logic             irq_ack_i,
   input  logic             clear_i,
   output logic             halt_commit_o,
   output logic             irq_o,
   output logic             checker_rst_o,
   output logic             lockdown_o,
   output logic [PC_W-1:0]  fault_pc_o,
   output logic [CNT_W-1:0] violation_cnt_o,
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ALARM    = 3'd1,
      ST_HALTED   = 3'd2,
      ST_RECOVER  = 3'd3,
      ST_LOCKDOWN = 3'd4
   } state_t;

   // Wait counter only has to reach ACK_TIMEOUT-1 before ALARM is left.
   localparam int WAIT_W = $clog2(ACK_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W:0]    MAX_VIOL_C = (CNT_W+1)'(MAX_VIOL);

   state_t            r_state;
   state_t            w_next;
   logic [WAIT_W-1:0] r_wait;
   logic [PC_W-1:0]   r_last_pc;
   logic [PC_W-1:0]   r_fault_pc;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_halt;
   logic              r_irq;
   logic              r_chk_rst;
   logic              r_lock;

   // One bit wider than the counter so the escalation compare sees the true cnt+1 even at saturation.
   logic [CNT_W:0]    w_cnt_inc;
   logic              w_capture;
   logic              w_escalate;
   logic              w_timeout;

   // Next-state decode; a violation is only accepted (and counted) from IDLE.
   always_comb begin
      w_next     = r_state;
      w_cnt_inc  = {1'b0, r_cnt} + (CNT_W+1)'(1);
      w_escalate = (w_cnt_inc >= MAX_VIOL_C);
      w_capture  = (r_state == ST_IDLE) && violation_i;
      w_timeout  = (r_wait == WAIT_LAST);
      case (r_state)
         ST_IDLE: begin
            if (violation_i) begin
               w_next = w_escalate ? ST_LOCKDOWN : ST_ALARM;
            end
         end
         ST_ALARM: begin
            // Ack beats a timeout that lands in the same cycle.
            if (irq_ack_i) begin
               w_next = ST_HALTED;
            end else if (w_timeout) begin
               w_next = ST_LOCKDOWN;
            end
         end
         ST_HALTED: begin
            if (clear_i) begin
               w_next = ST_RECOVER;
            end
         end
         ST_RECOVER:  w_next = ST_IDLE;
         ST_LOCKDOWN: w_next = ST_LOCKDOWN;
         default:     w_next = ST_IDLE;
      endcase
   end

   // State register plus output flags registered from the next state so every output is a flop.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= ST_IDLE;
         r_halt    <= 1'b0;
         r_irq     <= 1'b0;
         r_chk_rst <= 1'b0;
         r_lock    <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_halt    <= (w_next != ST_IDLE);
         r_irq     <= (w_next == ST_ALARM) || (w_next == ST_LOCKDOWN);
         r_chk_rst <= (w_next == ST_RECOVER);
         r_lock    <= (w_next == ST_LOCKDOWN);
      end
   end

   // Cycles spent waiting for the interrupt ack; held at zero outside ALARM.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wait <= '0;
      end else if (r_state == ST_ALARM) begin
         r_wait <= r_wait + WAIT_W'(1);
      end else begin
         r_wait <= '0;
      end
   end

   // Track the most recent committed PC so a violation without a same-cycle commit still has a PC.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_last_pc <= '0;
      end else if (commit_valid_i) begin
         r_last_pc <= commit_pc_i;
      end
   end

   // Capture fault PC and bump the saturating violation count on an accepted violation.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_fault_pc <= '0;
         r_cnt      <= '0;
      end else if (w_capture) begin
         r_fault_pc <= commit_valid_i ? commit_pc_i : r_last_pc;
         r_cnt      <= w_cnt_inc[CNT_W] ? '1 : w_cnt_inc[CNT_W-1:0];
      end
   end

   assign halt_commit_o   = r_halt;
   assign irq_o           = r_irq;
   assign checker_rst_o   = r_chk_rst;
   assign lockdown_o      = r_lock;
   assign fault_pc_o      = r_fault_pc;
   assign violation_cnt_o = r_cnt;
   assign state_o         = r_state;

endmodule

// File: tb/tb_cfi_alarm_ctrl.sv
// Bench for cfi_alarm_ctrl: two instances (MAX_VIOL 4 and 2, ACK_TIMEOUT 8) on shared stimulus.
// Latency: compares one step after each rising edge against a behavioural model.
// Backpressure: none; inputs are driven freely between edges.
module tb_cfi_alarm_ctrl;

   localparam int PC_W = 64;
   localparam int CNT_W = 8;
   localparam int TO = 8;
   localparam int MV_A = 4;
   localparam int MV_B = 2;

   localparam int S_IDLE = 0;
   localparam int S_ALARM = 1;
   localparam int S_HALTED = 2;
   localparam int S_RECOVER = 3;
   localparam int S_LOCK = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst = 1'b1;
   logic            v = 1'b0;
   logic            cv = 1'b0;
   logic [PC_W-1:0] pc = '0;
   logic            ack = 1'b0;
   logic            clr = 1'b0;

   logic             halt_a, irq_a, crst_a, lock_a;
   logic [PC_W-1:0]  fpc_a;
   logic [CNT_W-1:0] cnt_a;
   logic [2:0]       st_a;
   logic             halt_b, irq_b, crst_b, lock_b;
   logic [PC_W-1:0]  fpc_b;
   logic [CNT_W-1:0] cnt_b;
   logic [2:0]       st_b;

   logic [78:0] obs_a, obs_b;
   assign obs_a = {halt_a, irq_a, crst_a, lock_a, fpc_a, cnt_a, st_a};
   assign obs_b = {halt_b, irq_b, crst_b, lock_b, fpc_b, cnt_b, st_b};

   cfi_alarm_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .MAX_VIOL(MV_A), .ACK_TIMEOUT(TO)) dut_a (
      .clk_i(clk), .rst_i(rst), .violation_i(v), .commit_valid_i(cv), .commit_pc_i(pc),
      .irq_ack_i(ack), .clear_i(clr), .halt_commit_o(halt_a), .irq_o(irq_a),
      .checker_rst_o(crst_a), .lockdown_o(lock_a), .fault_pc_o(fpc_a),
      .violation_cnt_o(cnt_a), .state_o(st_a));

   cfi_alarm_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .MAX_VIOL(MV_B), .ACK_TIMEOUT(TO)) dut_b (
      .clk_i(clk), .rst_i(rst), .violation_i(v), .commit_valid_i(cv), .commit_pc_i(pc),
      .irq_ack_i(ack), .clear_i(clr), .halt_commit_o(halt_b), .irq_o(irq_b),
      .checker_rst_o(crst_b), .lockdown_o(lock_b), .fault_pc_o(fpc_b),
      .violation_cnt_o(cnt_b), .state_o(st_b));

   int n_checks = 0;
   int n_err = 0;

   // Reference model: mode per instance, count, captured PC, and the edge index at which the alarm was raised.
   int              m_mode [2];
   int              m_cnt [2];
   logic [PC_W-1:0] m_fpc [2];
   int              m_since [2];
   logic [PC_W-1:0] m_last = '0;
   int              cyc = 0;
   logic            prev_crst_a = 1'b0;
   logic            prev_crst_b = 1'b0;

   function automatic int mv(input int i);
      return (i == 0) ? MV_A : MV_B;
   endfunction

   function automatic logic [78:0] exp_vec(input int i);
      logic h, q, c, l;
      h = (m_mode[i] != S_IDLE);
      q = (m_mode[i] == S_ALARM) || (m_mode[i] == S_LOCK);
      c = (m_mode[i] == S_RECOVER);
      l = (m_mode[i] == S_LOCK);
      return {h, q, c, l, m_fpc[i], 8'(m_cnt[i]), 3'(m_mode[i])};
   endfunction

   task automatic chk(input string tag, input logic [78:0] obs, input logic [78:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_mode[i] = S_IDLE;
            m_cnt[i]  = 0;
            m_fpc[i]  = '0;
         end else begin
            case (m_mode[i])
               S_IDLE: begin
                  if (v) begin
                     m_fpc[i] = cv ? pc : m_last;
                     if (m_cnt[i] < 255) m_cnt[i]++;
                     m_mode[i]  = (m_cnt[i] >= mv(i)) ? S_LOCK : S_ALARM;
                     m_since[i] = cyc;
                  end
               end
               S_ALARM: begin
                  if (ack) m_mode[i] = S_HALTED;
                  else if (cyc - m_since[i] >= TO) m_mode[i] = S_LOCK;
               end
               S_HALTED:  if (clr) m_mode[i] = S_RECOVER;
               S_RECOVER: m_mode[i] = S_IDLE;
               default: ;
            endcase
         end
      end
      if (rst) m_last = '0;
      else if (cv) m_last = pc;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("model_a", obs_a, exp_vec(0));
      chk("model_b", obs_b, exp_vec(1));
      chk("crst_pulse_a", 79'(prev_crst_a & crst_a), 79'(0));
      chk("crst_pulse_b", 79'(prev_crst_b & crst_b), 79'(0));
      prev_crst_a = crst_a;
      prev_crst_b = crst_b;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_mode[i] = S_IDLE; m_cnt[i] = 0; m_fpc[i] = '0; m_since[i] = 0;
      end

      // Reset held two cycles
      step(); step();
      chk("rst_flags_a", 79'({halt_a, irq_a, crst_a, lock_a}), 79'(0));
      chk("rst_state_a", 79'(st_a), 79'(0));
      chk("rst_fpc_cnt_a", 79'({fpc_a, cnt_a}), 79'(0));
      chk("rst_all_b", obs_b, 79'(0));
      rst = 1'b0;

      // Basic flow
      cv = 1'b1; pc = 64'h8000_0010; step();
      cv = 1'b0; pc = 64'h0000_ffff; v = 1'b1; step();
      v = 1'b0;
      chk("basic_halt", 79'(halt_a), 79'(1));
      chk("basic_irq", 79'(irq_a), 79'(1));
      chk("basic_fpc", 79'(fpc_a), 79'(64'h8000_0010));
      chk("basic_cnt", 79'(cnt_a), 79'(1));
      chk("basic_state", 79'(st_a), 79'(S_ALARM));
      step(); step();
      ack = 1'b1; step(); ack = 1'b0;
      chk("ack_irq", 79'(irq_a), 79'(0));
      chk("ack_halt", 79'(halt_a), 79'(1));
      chk("ack_state", 79'(st_a), 79'(S_HALTED));
      clr = 1'b1; step(); clr = 1'b0;
      chk("clr_crst", 79'(crst_a), 79'(1));
      chk("clr_state", 79'(st_a), 79'(S_RECOVER));
      step();
      chk("recover_crst", 79'(crst_a), 79'(0));
      chk("recover_halt", 79'(halt_a), 79'(0));
      chk("recover_state", 79'(st_a), 79'(S_IDLE));
      chk("clear_keeps_cnt", 79'(cnt_a), 79'(1));

      // Same-cycle capture; second violation escalates instance b
      cv = 1'b1; pc = 64'hdead_beef; step();
      pc = 64'h1234; v = 1'b1; step();
      v = 1'b0; cv = 1'b0;
      chk("samecyc_fpc", 79'(fpc_a), 79'(64'h1234));
      chk("samecyc_cnt", 79'(cnt_a), 79'(2));
      chk("samecyc_state", 79'(st_a), 79'(S_ALARM));
      chk("escal_state_b", 79'(st_b), 79'(S_LOCK));
      chk("escal_lock_b", 79'(lock_b), 79'(1));
      chk("escal_cnt_b", 79'(cnt_b), 79'(2));

      // Ack timeout with clear asserted (ignored in ALARM and LOCKDOWN)
      clr = 1'b1;
      for (int k = 0; k < TO - 1; k++) begin
         step();
         chk("timeout_wait_a", 79'(st_a), 79'(S_ALARM));
         chk("lock_ignores_clr_b", 79'(st_b), 79'(S_LOCK));
      end
      step();
      clr = 1'b0;
      chk("timeout_lock_a", 79'(lock_a), 79'(1));
      chk("timeout_state_a", 79'(st_a), 79'(S_LOCK));
      ack = 1'b1; v = 1'b1; step(); ack = 1'b0; v = 1'b0;
      chk("lock_sticky_a", 79'(st_a), 79'(S_LOCK));
      chk("lock_no_count_a", 79'(cnt_a), 79'(2));

      // Reset exits lockdown
      rst = 1'b1; step(); step(); rst = 1'b0;
      chk("rst_lock_state_a", 79'(st_a), 79'(S_IDLE));
      chk("rst_lock_cnt_a", 79'(cnt_a), 79'(0));
      chk("rst_lock_flag_a", 79'(lock_a), 79'(0));

      // Ack coincident with timeout: ack wins
      v = 1'b1; step(); v = 1'b0;
      chk("coinc_entry", 79'(st_a), 79'(S_ALARM));
      for (int k = 0; k < TO - 1; k++) step();
      ack = 1'b1; step(); ack = 1'b0;
      chk("coinc_ack_wins", 79'(st_a), 79'(S_HALTED));
      chk("coinc_no_lock", 79'(lock_a), 79'(0));
      clr = 1'b1; step(); clr = 1'b0; step();

      // Reset in the middle of ALARM
      v = 1'b1; step(); v = 1'b0; step();
      chk("midalarm_pre", 79'(st_a), 79'(S_ALARM));
      rst = 1'b1; step();
      chk("midalarm_rst_state", 79'(st_a), 79'(S_IDLE));
      chk("midalarm_rst_cnt", 79'(cnt_a), 79'(0));
      chk("midalarm_rst_b", obs_b, 79'(0));
      step(); rst = 1'b0;

      // Stuck checker: violation held through ALARM/HALTED/RECOVER
      v = 1'b1; step();
      chk("stuck_entry", 79'(st_a), 79'(S_ALARM));
      ack = 1'b1; step(); ack = 1'b0;
      chk("stuck_halted_cnt", 79'(cnt_a), 79'(1));
      clr = 1'b1; step(); clr = 1'b0;
      chk("stuck_crst", 79'(crst_a), 79'(1));
      step();
      chk("stuck_crst_drop", 79'(crst_a), 79'(0));
      chk("stuck_idle", 79'(st_a), 79'(S_IDLE));
      step();
      chk("stuck_realarm", 79'(st_a), 79'(S_ALARM));
      chk("stuck_cnt", 79'(cnt_a), 79'(2));
      v = 1'b0;

      // Randomized traffic against the model
      for (int n = 0; n < 2000; n++) begin
         rst = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 3) == 0) v = ~v;
         cv  = 1'($urandom_range(0, 1));
         pc  = {$urandom, $urandom};
         ack = ($urandom_range(0, 3) == 0);
         clr = ($urandom_range(0, 3) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
